// File: rtl/idecode_sb_pipe.sv
// idecode_sb_pipe: MIPS decode stage with register file, immediate
// extension, per-register write scoreboard and a registered valid/ready
// output bundle. Write-back data selection (Jal / MemtoReg / ALU) is done here.
// Optional debug read port: define IDECODE_DBG_PORT_EN to add dbg_addr/dbg_data.
module idecode_sb_pipe #(
  parameter  int DATA_W  = 32,
  parameter  int REG_NUM = 32,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] opcplus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [DATA_W-1:0] imme_extend,
  output logic [DATA_W-1:0] out_pc4,
  output logic [AW-1:0]     out_dest,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_reg,
  input  logic              Jal,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] wb_pc4,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] ALU_result
`ifdef IDECODE_DBG_PORT_EN
  ,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [REG_NUM-1:0] pend;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [AW-1:0]      rs;
  logic [AW-1:0]      rt;
  logic [AW-1:0]      rd;
  logic [AW-1:0]      dest;
  logic               zero_ext;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_commit;
  logic [REG_NUM-1:0] clr_vec;
  logic [REG_NUM-1:0] live;
  logic               hazard;
  logic               accept;
  logic [DATA_W-1:0]  src1;
  logic [DATA_W-1:0]  src2;

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];
  assign rs     = Instruction[21 +: AW];
  assign rt     = Instruction[16 +: AW];
  assign rd     = Instruction[11 +: AW];

  // Destination register decode; index 0 means "no write".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dest = '0;
    case (opcode)
      6'h00:   dest = (funct == 6'h08) ? '0 : rd;
      6'h03:   dest = AW'(REG_NUM - 1);
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23:   dest = rt;
      default: dest = '0;
    endcase
  end

  // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
  assign zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
  assign imm_ext  = zero_ext ? {{(DATA_W-16){1'b0}}, Instruction[15:0]}
                             : {{(DATA_W-16){Instruction[15]}}, Instruction[15:0]};

  assign wb_data   = Jal ? wb_pc4 : (MemtoReg ? read_data : ALU_result);
  assign wb_commit = wb_valid && (wb_reg != '0);

  // Source reads bypass a same-cycle write-back so the stall releases with fresh data.
  assign src1 = (rs == '0) ? '0 : ((wb_commit && wb_reg == rs) ? wb_data : regs[rs]);
  assign src2 = (rt == '0) ? '0 : ((wb_commit && wb_reg == rt) ? wb_data : regs[rt]);

  // A register is still busy if pending and not being written back this cycle;
  // pend[0] is never set, so index 0 can never cause a stall.
  assign clr_vec = wb_valid ? (REG_NUM'(1) << wb_reg) : '0;
  assign live    = pend & ~clr_vec;
  assign hazard  = live[rs] || live[rt] || live[dest];

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Register file: write-back commit, register 0 never written.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every block
    // samples pre-edge values regardless of evaluation order.
    if (!reset) begin
      // NOTE: the array is cleared on reset because architectural state must
      // read as zero afterwards; this forces flops rather than a RAM macro.
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wb_commit) begin
      regs[wb_reg] <= wb_data;
    end
  end

  // Scoreboard: clear on write-back, then set on accept so a new writer wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      if (wb_valid) pend[wb_reg] <= 1'b0;
      if (accept && dest != '0) pend[dest] <= 1'b1;
    end
  end

  // Output bundle: load on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      read_data_1 <= '0;
      read_data_2 <= '0;
      imme_extend <= '0;
      out_pc4     <= '0;
      out_dest    <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      read_data_1 <= src1;
      read_data_2 <= src2;
      imme_extend <= imm_ext;
      out_pc4     <= opcplus4;
      out_dest    <= dest;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef IDECODE_DBG_PORT_EN
  // Debug read of the committed array only, no bypass.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif

endmodule

// File: tb/tb_idecode_sb_pipe.sv
// Scoreboard bench for idecode_sb_pipe: the stimulus thread pushes a
// hand-computed bundle per accepted instruction, a monitor pops on each
// output handshake.
module tb_idecode_sb_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Instruction;
  logic [31:0] opcplus4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imme_extend;
  logic [31:0] out_pc4;
  logic [4:0]  out_dest;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        Jal;
  logic        MemtoReg;
  logic [31:0] wb_pc4;
  logic [31:0] read_data;
  logic [31:0] ALU_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  dest;
  } exp_t;

  exp_t exp_q[$];

  idecode_sb_pipe dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Instruction (Instruction),
    .opcplus4    (opcplus4),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .imme_extend (imme_extend),
    .out_pc4     (out_pc4),
    .out_dest    (out_dest),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .Jal         (Jal),
    .MemtoReg    (MemtoReg),
    .wb_pc4      (wb_pc4),
    .read_data   (read_data),
    .ALU_result  (ALU_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [31:0] pc4, input logic [4:0] dest);
    exp_t e;
    e.tag = tag; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.pc4 = pc4; e.dest = dest;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an instruction until accepted (bounded); optionally require
  // acceptance in the first cycle and optionally record the expected bundle.
  task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                       input exp_t e, input bit expect_now, input bit push);
    bit done = 1'b0;
    in_valid    = 1'b1;
    Instruction = instr;
    opcplus4    = pc4;
    for (int w = 0; w < 20 && !done; w++) begin
      @(negedge clock);
      if (w == 0 && expect_now) check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
        if (push) exp_q.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_accept expected=accept", tag);
    end
  endtask

  // Monitor: compare every handshaken output bundle against the scoreboard.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bundle actual=dest%0d expected=none", out_dest);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_rd1"},  read_data_1, e.rd1);
        check({e.tag, "_rd2"},  read_data_2, e.rd2);
        check({e.tag, "_imm"},  imme_extend, e.imm);
        check({e.tag, "_pc4"},  out_pc4,     e.pc4);
        check({e.tag, "_dest"}, {27'd0, out_dest}, {27'd0, e.dest});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ra;
    logic [4:0] rb;
    reset = 1'b0; in_valid = 1'b0; Instruction = '0; opcplus4 = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_reg = '0; Jal = 1'b0; MemtoReg = 1'b0;
    wb_pc4 = '0; read_data = '0; ALU_result = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rd1", read_data_1, 32'd0);
    check("rst_imm", imme_extend, 32'd0);
    check("rst_dest", {27'd0, out_dest}, 32'd0);
    tick();
    reset = 1'b1;

    // Every register reads zero after reset (rd=0, so nothing becomes pending)
    for (int i = 0; i < 32; i += 2) begin
      ra = 5'(i);
      rb = 5'(i + 1);
      issue("regzero", {6'h00, ra, rb, 10'd0, 6'h20}, 32'(i * 4),
            mk("regzero", 32'd0, 32'd0, 32'h20, 32'(i * 4), 5'd0), 1'b1, 1'b1);
    end

    // ALU write-back to $5, then addi $6,$5,-1
    wb_valid = 1'b1; wb_reg = 5'd5; MemtoReg = 1'b0; ALU_result = 32'h1234;
    read_data = 32'h7777; wb_pc4 = 32'h6666;
    tick();
    wb_valid = 1'b0;
    issue("addi", 32'h20A6FFFF, 32'h100, mk("addi", 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h100, 5'd6), 1'b1, 1'b1);

    // ori zero-extends; andi zero-extends; slti sign-extends
    issue("ori",  32'h34078000, 32'h104, mk("ori",  32'd0, 32'd0, 32'h00008000, 32'h104, 5'd7),  1'b1, 1'b1);
    issue("andi", 32'h3014F00F, 32'h108, mk("andi", 32'd0, 32'd0, 32'h0000F00F, 32'h108, 5'd20), 1'b1, 1'b1);
    issue("slti", 32'h28158001, 32'h10C, mk("slti", 32'd0, 32'd0, 32'hFFFF8001, 32'h10C, 5'd21), 1'b1, 1'b1);

    // No-destination opcodes: jr, beq, sw
    issue("jr",  32'h00A00008, 32'h110, mk("jr",  32'h1234, 32'd0, 32'h00000008, 32'h110, 5'd0), 1'b1, 1'b1);
    issue("beq", 32'h1000FFFE, 32'h114, mk("beq", 32'd0,    32'd0, 32'hFFFFFFFE, 32'h114, 5'd0), 1'b1, 1'b1);
    issue("sw",  32'hAC050004, 32'h118, mk("sw",  32'd0, 32'h1234, 32'h00000004, 32'h118, 5'd0), 1'b1, 1'b1);

    // Write-back to $0 is ignored, including same-cycle bypass
    wb_valid = 1'b1; wb_reg = 5'd0; ALU_result = 32'hDEAD;
    tick();
    issue("r0", 32'h00005820, 32'h11C, mk("r0", 32'd0, 32'd0, 32'h00005820, 32'h11C, 5'd11), 1'b1, 1'b1);
    wb_valid = 1'b0;

    // Jal-selected write-back data to $12, then add $13,$12,$5
    wb_valid = 1'b1; wb_reg = 5'd12; Jal = 1'b1; wb_pc4 = 32'h88; ALU_result = 32'h99; read_data = 32'h77;
    tick();
    wb_valid = 1'b0; Jal = 1'b0;
    issue("jalwb", 32'h01856820, 32'h120, mk("jalwb", 32'h88, 32'h1234, 32'h00006820, 32'h120, 5'd13), 1'b1, 1'b1);

    // RAW hazard: lw $8 then add $10,$8,$8 stalls until load write-back
    issue("lw", 32'h8D280000, 32'h124, mk("lw", 32'd0, 32'd0, 32'd0, 32'h124, 5'd8), 1'b1, 1'b1);
    in_valid = 1'b1; Instruction = 32'h01085020; opcplus4 = 32'h128;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("raw_stall", {31'd0, in_ready}, 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_reg = 5'd8; MemtoReg = 1'b1; read_data = 32'hCAFE; ALU_result = 32'h1111;
    @(negedge clock);
    check("raw_release", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(mk("bypass", 32'hCAFE, 32'hCAFE, 32'h00005020, 32'h128, 5'd10));
    tick();
    in_valid = 1'b0; wb_valid = 1'b0; MemtoReg = 1'b0;

    // pend[8] cleared: $8 now reads the committed value without stalling
    issue("p8clr", 32'h01007020, 32'h12C, mk("p8clr", 32'hCAFE, 32'd0, 32'h00007020, 32'h12C, 5'd14), 1'b1, 1'b1);

    // pend[10] set: add $15,$10,$0 stalls, then releases on write-back with bypass
    in_valid = 1'b1; Instruction = 32'h01407820; opcplus4 = 32'h130;
    @(negedge clock);
    check("p10_stall", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b1; wb_reg = 5'd10; ALU_result = 32'h55;
    issue("p10rel", 32'h01407820, 32'h130, mk("p10rel", 32'h55, 32'd0, 32'h00007820, 32'h130, 5'd15), 1'b1, 1'b1);
    wb_valid = 1'b0;

    // Backpressure: output held stable for 3 cycles, then 1/cycle throughput
    tick();
    out_ready = 1'b0;
    issue("hold", 32'h34130044, 32'h200, mk("hold", 32'd0, 32'd0, 32'h44, 32'h200, 5'd19), 1'b1, 1'b1);
    in_valid = 1'b1; Instruction = 32'h34100001; opcplus4 = 32'h204;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_imm",   imme_extend, 32'h44);
      check("hold_pc4",   out_pc4, 32'h200);
      check("hold_dest",  {27'd0, out_dest}, 32'd19);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    issue("b2b16", 32'h34100001, 32'h204, mk("b2b16", 32'd0, 32'd0, 32'h1, 32'h204, 5'd16), 1'b1, 1'b1);
    issue("b2b17", 32'h34110002, 32'h208, mk("b2b17", 32'd0, 32'd0, 32'h2, 32'h208, 5'd17), 1'b1, 1'b1);
    issue("b2b18", 32'h34120003, 32'h20C, mk("b2b18", 32'd0, 32'd0, 32'h3, 32'h20C, 5'd18), 1'b1, 1'b1);

    // jal: destination is the last register, PC+4 carried through
    issue("jal", 32'h0C000010, 32'h40, mk("jal", 32'd0, 32'd0, 32'h10, 32'h40, 5'd31), 1'b1, 1'b1);

    // Reset mid-stall discards the held bundle and drops the write-back
    tick();
    out_ready = 1'b0;
    issue("doomed", 32'h34160005, 32'h300, mk("doomed", 32'd0, 32'd0, 32'h5, 32'h300, 5'd22), 1'b1, 1'b0);
    in_valid = 1'b1; Instruction = 32'h34170006; opcplus4 = 32'h304;
    @(negedge clock);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_dest", {27'd0, out_dest}, 32'd22);
    tick();
    reset = 1'b0; wb_valid = 1'b1; wb_reg = 5'd5; ALU_result = 32'hBAD;
    tick();
    @(negedge clock);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_dest", {27'd0, out_dest}, 32'd0);
    check("mrst_imm", imme_extend, 32'd0);
    check("mrst_pc4", out_pc4, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;

    // After reset: nothing pending (WAW on $7/$6, RAW on $31) and array cleared
    issue("post1", 32'h00AC3820, 32'h400, mk("post1", 32'd0, 32'd0, 32'h00003820, 32'h400, 5'd7), 1'b1, 1'b1);
    issue("post2", 32'h03E83020, 32'h404, mk("post2", 32'd0, 32'd0, 32'h00003020, 32'h404, 5'd6), 1'b1, 1'b1);

    // Drain the scoreboard (bounded)
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idecode_sb_pipe.md
Name: idecode_sb_pipe

Overview:
- Parametrised decode stage: register file (REG_NUM x DATA_W), immediate extension, and a registered decode output with valid/ready handshake.
- A per-register scoreboard stalls instructions whose sources or destination have an outstanding write.
- Write-back data selection (Jal / MemtoReg / ALU) is performed internally, as in the previous-generation decoder.
- Sits between instruction fetch and execute in the CPU pipeline.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_NUM, 32, number of architectural registers; power of two, 2..32.
- AW, $clog2(REG_NUM), register index width; derived, not to be overridden.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset; sampled on posedge clock.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts this cycle.
- Instruction  in  32  MIPS instruction word.
- opcplus4  in  DATA_W  PC+4 of the incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- read_data_1  out  DATA_W  registered rs value.
- read_data_2  out  DATA_W  registered rt value.
- imme_extend  out  DATA_W  registered extended immediate.
- out_pc4  out  DATA_W  registered PC+4.
- out_dest  out  AW  registered destination index (0 = no write).
- wb_valid  in  1  write-back strobe.
- wb_reg  in  AW  write-back destination index.
- Jal  in  1  write-back selects wb_pc4.
- MemtoReg  in  1  write-back selects read_data, else ALU_result.
- wb_pc4  in  DATA_W  PC+4 for jal link.
- read_data  in  DATA_W  memory/IO load data.
- ALU_result  in  DATA_W  ALU result.

Behaviour:
- Field extraction: rs=Instruction[25:21], rt=[20:16], rd=[15:11]; each truncated to AW bits.
- Destination decode:
  - opcode 0x00: rd, except funct 0x08 (jr), which gives 0.
  - opcode 0x03 (jal): REG_NUM-1.
  - opcodes 0x08–0x0F and 0x23: rt.
  - all other opcodes: 0.
- Immediate: opcodes 0x0C/0x0D/0x0E zero-extend Instruction[15:0] to DATA_W; all others sign-extend.
- Write-back data: Jal ? wb_pc4 : MemtoReg ? read_data : ALU_result.
- Write-back commit: register[wb_reg] is written on posedge when wb_valid=1 and wb_reg!=0. Register 0 always reads 0.
- Bypass: if wb_valid=1 and wb_reg equals a nonzero source index in the same cycle, the source reads the write-back data, not the stale array value.
- Scoreboard: pend[REG_NUM-1:0]; pend[0] is always 0.
- hazard=1 when any of the following is pending and not being cleared this cycle (pending = pend[i] set; cleared = wb_valid with wb_reg==i):
  - rs, when nonzero;
  - rt, when nonzero;
  - the decoded destination, when nonzero (WAW).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - accept = in_valid && in_ready.
  - On accept, latch read_data_1, read_data_2, imme_extend, out_pc4, out_dest; out_valid<=1; set pend[dest] if dest!=0.
  - Else, if out_ready, out_valid<=0.
- Output stability: output registers hold their values while out_valid && !out_ready.
- Simultaneous clear and set on the same index: set wins (new writer owns the register).
- Latency: one cycle from accept to out_valid. Sustained throughput is 1/cycle when hazard-free.
- Reset (reset==0 at posedge), which overrides all other activity, including mid-handshake:
  - all registers and outputs go to 0: register array, pend, out_valid, and all bundle outputs;
  - an in-flight bundle is discarded;
  - write-backs in the reset cycle are dropped.

Optional Feature:
- Macro: IDECODE_DBG_PORT_EN.
- When defined, two ports are added:
  - dbg_addr  in  AW;
  - dbg_data  out  DATA_W — combinational read of register[dbg_addr], with no bypass; register 0 reads 0.
- Used by the board seven-segment/LED debug path.
- When undefined, these ports do not exist and no extra logic is generated.

Test Plan:
- Reset, then release reset: read all registers via decode → every value is 0, out_valid=0, pend=0.
- wb_valid=1, wb_reg=5, MemtoReg=0, ALU_result=0x1234 → next cycle, addi $6,$5,-1 (0x20A6FFFF) decodes to read_data_1=0x1234, imme_extend=0xFFFFFFFF, out_dest=6.
- ori $7,$0,0x8000 → imme_extend=0x00008000. Write-back to $0 with 0xDEAD → $0 still reads 0.
- lw $8,0($9) accepted, then add $10,$8,$8 presented:
  - in_ready=0 until wb_valid with wb_reg=8 and read_data=0xCAFE arrives;
  - that same cycle, accept occurs with read_data_1=read_data_2=0xCAFE (bypass);
  - pend[8] clears; pend[10] sets.
- out_ready held 0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. Releasing out_ready → back-to-back accepts at 1 per cycle.
- jal (0x0C000010) with opcplus4=0x40 → out_dest=31, out_pc4=0x40. Reset asserted mid-stall → out_valid=0 and pend=0 on the next cycle.
